// File: rtl/execute_stage.sv
// EX stage of a 5-stage MIPS-style pipeline: operand mux, ALU, branch target and destination
// select, all captured into the EX/MEM pipeline register with stall/flush control.
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  id_ex_wb,
    input  logic [2:0]  id_ex_mem,
    input  logic [3:0]  id_ex_execute,
    input  logic [31:0] id_ex_npc,
    input  logic [31:0] id_ex_readdat1,
    input  logic [31:0] id_ex_readdat2,
    input  logic [31:0] id_ex_sign_ext,
    input  logic [4:0]  id_ex_instr_bits_20_16,
    input  logic [4:0]  id_ex_instr_bits_15_11,
    output logic [1:0]  ex_mem_wb,
    output logic [2:0]  ex_mem_mem,
    output logic [31:0] ex_mem_branch_target,
    output logic        ex_mem_zero,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_readdat2,
    output logic [4:0]  ex_mem_write_reg
);

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [31:0] branch_target;
    logic [4:0]  write_reg;

    logic [1:0]  wb_q;
    logic [2:0]  mem_q;
    logic [31:0] branch_target_q;
    logic        zero_q;
    logic [31:0] alu_result_q;
    logic [31:0] readdat2_q;
    logic [4:0]  write_reg_q;

    // execute[1] is spare and the top two immediate bits fall off the word-aligned shift.
    logic unused_bits;
    assign unused_bits = ^{id_ex_execute[1], id_ex_sign_ext[31:30]};

    assign op_b          = id_ex_execute[0] ? id_ex_sign_ext : id_ex_readdat2;
    assign branch_target = id_ex_npc + {id_ex_sign_ext[29:0], 2'b00};
    assign write_reg     = id_ex_execute[3] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;

    always_comb begin
        alu_result = '0;
        case (id_ex_execute[3:2])
            2'b00, 2'b10: alu_result = id_ex_readdat1 + op_b;
            2'b01:        alu_result = id_ex_readdat1 - op_b;
            default: begin
                case (id_ex_sign_ext[5:0])
                    FunctAdd: alu_result = id_ex_readdat1 + op_b;
                    FunctSub: alu_result = id_ex_readdat1 - op_b;
                    FunctAnd: alu_result = id_ex_readdat1 & op_b;
                    FunctOr:  alu_result = id_ex_readdat1 | op_b;
                    FunctSlt: alu_result = {31'd0, $signed(id_ex_readdat1) < $signed(op_b)};
                    default:  alu_result = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q            <= '0;
            mem_q           <= '0;
            branch_target_q <= '0;
            zero_q          <= 1'b0;
            alu_result_q    <= '0;
            readdat2_q      <= '0;
            write_reg_q     <= '0;
        end else begin
            // A flush still captures the data path; only the control bits become a bubble.
            if (flush || !stall) begin
                branch_target_q <= branch_target;
                zero_q          <= (alu_result == 32'd0);
                alu_result_q    <= alu_result;
                readdat2_q      <= id_ex_readdat2;
                write_reg_q     <= write_reg;
            end
            if (flush) begin
                wb_q  <= '0;
                mem_q <= '0;
            end else if (!stall) begin
                wb_q  <= id_ex_wb;
                mem_q <= id_ex_mem;
            end
        end
    end

    assign ex_mem_wb            = wb_q;
    assign ex_mem_mem           = mem_q;
    assign ex_mem_branch_target = branch_target_q;
    assign ex_mem_zero          = zero_q;
    assign ex_mem_alu_result    = alu_result_q;
    assign ex_mem_readdat2      = readdat2_q;
    assign ex_mem_write_reg     = write_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, stall/flush and async-reset sequences, then
// random traffic checked against an arithmetic reference model.
module tb_execute_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] bt;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wr;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_execute;
    logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [4:0]  id_ex_instr_bits_20_16, id_ex_instr_bits_15_11;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_mem;
    logic [31:0] ex_mem_branch_target, ex_mem_alu_result, ex_mem_readdat2;
    logic        ex_mem_zero;
    logic [4:0]  ex_mem_write_reg;

    int   n_vec = 0;
    int   n_bad = 0;
    out_t exp_q;
    vec_t tbl[11];

    execute_stage dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .stall                  (stall),
        .flush                  (flush),
        .id_ex_wb               (id_ex_wb),
        .id_ex_mem              (id_ex_mem),
        .id_ex_execute          (id_ex_execute),
        .id_ex_npc              (id_ex_npc),
        .id_ex_readdat1         (id_ex_readdat1),
        .id_ex_readdat2         (id_ex_readdat2),
        .id_ex_sign_ext         (id_ex_sign_ext),
        .id_ex_instr_bits_20_16 (id_ex_instr_bits_20_16),
        .id_ex_instr_bits_15_11 (id_ex_instr_bits_15_11),
        .ex_mem_wb              (ex_mem_wb),
        .ex_mem_mem             (ex_mem_mem),
        .ex_mem_branch_target   (ex_mem_branch_target),
        .ex_mem_zero            (ex_mem_zero),
        .ex_mem_alu_result      (ex_mem_alu_result),
        .ex_mem_readdat2        (ex_mem_readdat2),
        .ex_mem_write_reg       (ex_mem_write_reg)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(logic [1:0] wb, logic [2:0] mem, logic [3:0] ex, logic [31:0] npc,
                               logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [4:0] rt,
                               logic [4:0] rd);
        in_t r;
        r = '{wb: wb, mem: mem, ex: ex, npc: npc, a: a, b: b, imm: imm, rt: rt, rd: rd};
        return r;
    endfunction

    function automatic out_t mo(logic [1:0] wb, logic [2:0] mem, logic [31:0] bt, logic zero,
                                logic [31:0] alu, logic [31:0] rd2, logic [4:0] wr);
        out_t r;
        r = '{wb: wb, mem: mem, bt: bt, zero: zero, alu: alu, rd2: rd2, wr: wr};
        return r;
    endfunction

    // Reference: what the instruction computes, written from the ISA rules.
    function automatic out_t calc(in_t x);
        out_t        r;
        logic [31:0] opb;
        longint      res;
        int          funct;
        opb   = x.ex[0] ? x.imm : x.b;
        funct = int'(x.imm & 32'h3F);
        res   = 0;
        if (x.ex[3:2] == 2'd0 || x.ex[3:2] == 2'd2) res = longint'(x.a) + longint'(opb);
        else if (x.ex[3:2] == 2'd1) res = longint'(x.a) - longint'(opb);
        else if (funct == 32) res = longint'(x.a) + longint'(opb);
        else if (funct == 34) res = longint'(x.a) - longint'(opb);
        else if (funct == 36) res = longint'(x.a & opb);
        else if (funct == 37) res = longint'(x.a | opb);
        else if (funct == 42) res = (int'(x.a) < int'(opb)) ? 1 : 0;
        r.alu  = res[31:0];
        r.zero = (r.alu == 0);
        r.bt   = x.npc + x.imm * 4;
        r.rd2  = x.b;
        r.wr   = x.ex[3] ? x.rd : x.rt;
        r.wb   = x.wb;
        r.mem  = x.mem;
        return r;
    endfunction

    function automatic void model_edge(in_t x, logic st, logic fl);
        out_t n;
        n = calc(x);
        if (fl) begin
            n.wb  = '0;
            n.mem = '0;
            exp_q = n;
        end else if (!st) begin
            exp_q = n;
        end
    endfunction

    task automatic drive(in_t x, logic st, logic fl);
        id_ex_wb               = x.wb;
        id_ex_mem              = x.mem;
        id_ex_execute          = x.ex;
        id_ex_npc              = x.npc;
        id_ex_readdat1         = x.a;
        id_ex_readdat2         = x.b;
        id_ex_sign_ext         = x.imm;
        id_ex_instr_bits_20_16 = x.rt;
        id_ex_instr_bits_15_11 = x.rd;
        stall                  = st;
        flush                  = fl;
    endtask

    task automatic check(string name, out_t want);
        out_t got;
        got = '{wb: ex_mem_wb, mem: ex_mem_mem, bt: ex_mem_branch_target, zero: ex_mem_zero,
                alu: ex_mem_alu_result, rd2: ex_mem_readdat2, wr: ex_mem_write_reg};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got wb=%b mem=%b bt=%h z=%b alu=%h rd2=%h wr=%0d, want wb=%b mem=%b bt=%h z=%b alu=%h rd2=%h wr=%0d",
                     name, got.wb, got.mem, got.bt, got.zero, got.alu, got.rd2, got.wr,
                     want.wb, want.mem, want.bt, want.zero, want.alu, want.rd2, want.wr);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and check just after the rising edge.
    task automatic step(string name, in_t x, logic st, logic fl);
        @(negedge clk);
        drive(x, st, fl);
        @(posedge clk);
        model_edge(x, st, fl);
        #1;
        check(name, exp_q);
    endtask

    function automatic in_t rand_in();
        in_t         x;
        logic [31:0] r;
        int          sel;
        x.wb  = 2'($urandom);
        x.mem = 3'($urandom);
        x.ex  = 4'($urandom);
        x.npc = $urandom;
        x.a   = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
        x.b   = ($urandom_range(0, 4) == 0) ? x.a : $urandom;
        r     = $urandom;
        sel   = $urandom_range(0, 5);
        case (sel)
            0: x.imm = {r[31:6], 6'b100000};
            1: x.imm = {r[31:6], 6'b100010};
            2: x.imm = {r[31:6], 6'b100100};
            3: x.imm = {r[31:6], 6'b100101};
            4: x.imm = {r[31:6], 6'b101010};
            default: x.imm = r;
        endcase
        x.rt = 5'($urandom);
        x.rd = 5'($urandom);
        return x;
    endfunction

    initial begin
        in_t x;

        tbl[0]  = '{mk(2'b01, 3'b000, 4'b1100, 32'h40, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3),
                    mo(2'b01, 3'b000, 32'hC0, 1'b0, 32'd12, 32'd7, 5'd3)};
        tbl[1]  = '{mk(2'b11, 3'b010, 4'b0001, 32'h100, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd2, 5'd31),
                    mo(2'b11, 3'b010, 32'hF0, 1'b0, 32'hFC, 32'h55, 5'd2)};
        tbl[2]  = '{mk(2'b00, 3'b100, 4'b0100, 32'h20, 32'd9, 32'd9, 32'd3, 5'd5, 5'd6),
                    mo(2'b00, 3'b100, 32'h2C, 1'b1, 32'd0, 32'd9, 5'd5)};
        tbl[3]  = '{mk(2'b01, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd8, 5'd4),
                    mo(2'b01, 3'b000, 32'hA8, 1'b0, 32'd1, 32'd1, 5'd4)};
        tbl[4]  = '{mk(2'b01, 3'b000, 4'b1100, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd8, 5'd4),
                    mo(2'b01, 3'b000, 32'hA8, 1'b1, 32'd0, 32'hFFFFFFFF, 5'd4)};
        tbl[5]  = '{mk(2'b01, 3'b000, 4'b1100, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h24, 5'd8, 5'd7),
                    mo(2'b01, 3'b000, 32'h90, 1'b0, 32'h00F000F0, 32'h0FF00FF0, 5'd7)};
        tbl[6]  = '{mk(2'b01, 3'b000, 4'b1100, 32'h0, 32'hF0000000, 32'hF, 32'h25, 5'd8, 5'd7),
                    mo(2'b01, 3'b000, 32'h94, 1'b0, 32'hF000000F, 32'hF, 5'd7)};
        tbl[7]  = '{mk(2'b01, 3'b000, 4'b1100, 32'h0, 32'd1, 32'd2, 32'h3F, 5'd8, 5'd7),
                    mo(2'b01, 3'b000, 32'hFC, 1'b1, 32'd0, 32'd2, 5'd7)};
        tbl[8]  = '{mk(2'b01, 3'b000, 4'b1100, 32'h0, 32'd0, 32'd1, 32'h22, 5'd8, 5'd7),
                    mo(2'b01, 3'b000, 32'h88, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd7)};
        tbl[9]  = '{mk(2'b01, 3'b000, 4'b1000, 32'h1000, 32'hFFFFFFFF, 32'd2, 32'h0, 5'd8, 5'd7),
                    mo(2'b01, 3'b000, 32'h1000, 1'b0, 32'd1, 32'd2, 5'd7)};
        tbl[10] = '{mk(2'b01, 3'b000, 4'b0101, 32'h4, 32'd10, 32'd3, 32'hA, 5'd8, 5'd7),
                    mo(2'b01, 3'b000, 32'h2C, 1'b1, 32'd0, 32'd3, 5'd8)};

        // Reset held from time zero with live inputs.
        rst_n = 1'b0;
        drive(tbl[0].in, 1'b0, 1'b0);
        exp_q = '0;
        #1;
        check("reset_t0", exp_q);
        @(posedge clk);
        #1;
        check("reset_held", exp_q);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i].in, 1'b0, 1'b0);
            @(posedge clk);
            model_edge(tbl[i].in, 1'b0, 1'b0);
            #1;
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Load, stall twice with changing inputs, then stall+flush together.
        step("load", tbl[1].in, 1'b0, 1'b0);
        step("stall1", tbl[2].in, 1'b1, 1'b0);
        check("stall1_const", tbl[1].exp);
        step("stall2", tbl[5].in, 1'b1, 1'b0);
        step("stall_flush", tbl[0].in, 1'b1, 1'b1);
        check("stall_flush_const", mo(2'b00, 3'b000, 32'hC0, 1'b0, 32'd12, 32'd7, 5'd3));
        step("flush_only", tbl[1].in, 1'b0, 1'b1);
        step("after_flush", tbl[1].in, 1'b0, 1'b0);

        // Async reset dropped mid-cycle while outputs are nonzero.
        @(negedge clk);
        drive(tbl[2].in, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q = '0;
        #1;
        check("async_reset", exp_q);
        @(posedge clk);
        #1;
        check("reset_through_edge", exp_q);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("reset_released", exp_q);
        @(posedge clk);
        model_edge(tbl[2].in, 1'b0, 1'b0);
        #1;
        check("first_edge_after_reset", tbl[2].exp);

        for (int i = 0; i < 400; i++) begin
            x = rand_in();
            step("random", x, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stall  in  1  hold the EX/MEM register contents this cycle.
REQ-005 flush  in  1  insert a bubble into EX/MEM this cycle.
REQ-006 id_ex_wb  in  2  write-back controls {memtoreg, regwrite}.
REQ-007 id_ex_mem  in  3  memory controls {branch, memread, memwrite}.
REQ-008 id_ex_execute  in  4  execute controls; [3] regdst, [3:2] ALU class, [1] unused, [0] alusrc.
REQ-009 id_ex_npc  in  32  PC+4 of the instruction.
REQ-010 id_ex_readdat1 / id_ex_readdat2  in  32 each  rs / rt operands.
REQ-011 id_ex_sign_ext  in  32  sign-extended immediate; [5:0] is funct for R-type.
REQ-012 id_ex_instr_bits_20_16 / id_ex_instr_bits_15_11  in  5 each  rt / rd fields.
REQ-013 ex_mem_wb  out  2  registered id_ex_wb.
REQ-014 ex_mem_mem  out  3  registered id_ex_mem.
REQ-015 ex_mem_branch_target  out  32  registered branch target.
REQ-016 ex_mem_zero  out  1  registered (ALU result == 0).
REQ-017 ex_mem_alu_result  out  32  registered ALU result.
REQ-018 ex_mem_readdat2  out  32  registered rt operand, used as store data.
REQ-019 ex_mem_write_reg  out  5  registered destination register number.

Function
REQ-020 Operand B SHALL be id_ex_sign_ext when id_ex_execute[0]=1, else id_ex_readdat2.
REQ-021 ALU class id_ex_execute[3:2]: 00 add, 01 subtract (A-B), 10 add, 11 funct-decoded.
REQ-022 Funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct gives result 0.
REQ-023 slt SHALL use a signed compare and give 32'd1 or 32'd0.
REQ-024 Add and sub SHALL wrap modulo 2^32; there is no overflow flag or trap.
REQ-025 Branch target SHALL be id_ex_npc + {id_ex_sign_ext[29:0], 2'b00}, modulo 2^32.
REQ-026 Write register SHALL be id_ex_instr_bits_15_11 when id_ex_execute[3]=1, else id_ex_instr_bits_20_16.
REQ-027 The ALU, the branch target and the write-register mux SHALL be combinational from the ID/EX inputs.
REQ-028 All outputs SHALL be registered, with exactly 1 cycle of latency from inputs to ex_mem_* outputs.
REQ-029 On a rising edge with flush=0 and stall=0, all EX/MEM fields SHALL load the new values.
REQ-030 With stall=1 and flush=0, all EX/MEM fields SHALL hold their values.
REQ-031 With flush=1, ex_mem_wb and ex_mem_mem SHALL load 0 and data fields SHALL load normally.
REQ-032 flush SHALL take priority over stall when both are 1.
REQ-033 ex_mem_zero SHALL be taken from the same ALU result that is registered in ex_mem_alu_result.

Reset
REQ-034 While rst_n=0, every output SHALL be 0, immediately and without waiting for a clock edge.
REQ-035 A reset asserted mid-operation SHALL discard the in-flight EX/MEM contents.
REQ-036 The first edge after rst_n rises SHALL load the inputs per REQ-029..032.

Verification
REQ-037 R-type add: execute=1100, funct=100000, A=5, B=7, rd=3 -> next edge alu_result=12, write_reg=3, zero=0, wb=01.
REQ-038 LW: execute=0001, A=0x100, imm=0xFFFFFFFC, rt=2 -> alu_result=0xFC, write_reg=2, mem=010, wb=11.
REQ-039 BEQ: execute=0100, A=B=9, npc=0x20, imm=3 -> zero=1, alu_result=0, branch_target=0x2C, mem=100.
REQ-040 slt: A=0xFFFFFFFF, B=1, funct=101010 -> result=1; with A=1, B=0xFFFFFFFF -> result=0.
REQ-041 Stall then flush: load one instruction, raise stall for 2 cycles while changing inputs -> outputs unchanged; then raise stall=1 and flush=1 together -> wb=00, mem=000, data fields take the new values.
REQ-042 Async reset: drop rst_n between clock edges while outputs are nonzero -> all outputs become 0 before the next edge and stay 0 until the first edge after release.
